// File: rtl/regfiles_read_port.sv
// Two-requester round-robin read front end for the 32x32 register file.
// Forwards same-cycle write data and returns one registered response.
module regfiles_read_port #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH*DEPTH-1:0] reg_flat,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   req0_valid,
  input  logic [AW-1:0]          req0_addr,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [AW-1:0]          req1_addr,
  output logic                   req1_ready,
  output logic                   rsp_valid,
  output logic                   rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  input  logic                   rsp_ready
);

  logic [WIDTH-1:0] regs [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_unflat
    assign regs[i] = reg_flat[i*WIDTH +: WIDTH];
  end

  logic             last;
  logic             can_accept;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             sel;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rval;

  assign can_accept = !rsp_valid || rsp_ready;
  assign grant0 = req0_valid && (!req1_valid || last);
  assign grant1 = req1_valid && (!req0_valid || !last);

  // Gated by rst so no handshake completes while reset is held.
  assign req0_ready = grant0 && can_accept && !rst;
  assign req1_ready = grant1 && can_accept && !rst;
  assign accept = req0_ready || req1_ready;
  assign sel = grant1;
  assign raddr = sel ? req1_addr : req0_addr;

  always_comb begin
    rval = '0;
    unique case (1'b1)
      (raddr == '0): rval = '0;
      (we && waddr == raddr && waddr != '0): rval = wdata;
      default: rval = regs[raddr];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      last      <= 1'b1;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= sel;
      rsp_data  <= rval;
      last      <= sel;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfiles_read_port.sv
// Directed bench for regfiles_read_port.
// Expected responses are queued at issue and checked by a monitor.
module tb_regfiles_read_port;

  logic          clk = 1'b0;
  logic          rst;
  logic [1023:0] reg_flat;
  logic          we;
  logic [4:0]    waddr;
  logic [31:0]   wdata;
  logic          req0_valid;
  logic [4:0]    req0_addr;
  logic          req0_ready;
  logic          req1_valid;
  logic [4:0]    req1_addr;
  logic          req1_ready;
  logic          rsp_valid;
  logic          rsp_id;
  logic [31:0]   rsp_data;
  logic          rsp_ready;

  logic [31:0] regs [32];
  logic [32:0] q [$];
  int n_chk = 0;
  int n_fail = 0;

  localparam logic [31:0] R3 = 32'h3333_0003;
  localparam logic [31:0] R5 = 32'h1234_5678;
  localparam logic [31:0] R7 = 32'h7777_0007;

  always #5 clk = ~clk;

  always_comb begin
    reg_flat = '0;
    for (int i = 0; i < 32; i++) reg_flat[i*32 +: 32] = regs[i];
  end

  regfiles_read_port dut (
    .clk(clk), .rst(rst), .reg_flat(reg_flat),
    .we(we), .waddr(waddr), .wdata(wdata),
    .req0_valid(req0_valid), .req0_addr(req0_addr),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr),
    .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response taken by the consumer must match the queue head.
  logic       p_v0, p_r0, p_v1, p_r1;
  logic [4:0] p_a0, p_a1;
  initial begin
    p_v0 = 0; p_r0 = 0; p_v1 = 0; p_r1 = 0; p_a0 = 0; p_a1 = 0;
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          logic [32:0] e;
          e = q.pop_front();
          chk("rsp_id", {31'd0, rsp_id}, {31'd0, e[32]});
          chk("rsp_data", rsp_data, e[31:0]);
        end
      end
      if (p_v0 && !p_r0)
        chk("req0_hold", {26'd0, req0_valid, req0_addr}, {26'd0, 1'b1, p_a0});
      if (p_v1 && !p_r1)
        chk("req1_hold", {26'd0, req1_valid, req1_addr}, {26'd0, 1'b1, p_a1});
    end
    p_v0 = req0_valid && !rst; p_r0 = req0_ready; p_a0 = req0_addr;
    p_v1 = req1_valid && !rst; p_r1 = req1_ready; p_a1 = req1_addr;
  end

  task automatic step(input logic v0, input logic [4:0] a0,
                      input logic v1, input logic [4:0] a1,
                      input logic rr, input logic w,
                      input logic [4:0] wa, input logic [31:0] wd,
                      input logic e0, input logic e1,
                      input logic [31:0] ed);
    req0_valid = v0; req0_addr = a0;
    req1_valid = v1; req1_addr = a1;
    rsp_ready = rr; we = w; waddr = wa; wdata = wd;
    @(negedge clk);
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
    if (e0) q.push_back({1'b0, ed});
    if (e1) q.push_back({1'b1, ed});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 | i;
    regs[3] = R3; regs[5] = R5; regs[7] = R7; regs[9] = 32'h0;
    rst = 1; we = 0; waddr = 0; wdata = 0; rsp_ready = 1;
    req0_valid = 1; req0_addr = 5'd5; req1_valid = 0; req1_addr = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_rdy0", {31'd0, req0_ready}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    @(posedge clk); #1;
    rst = 0;

    step(1, 5, 0, 0, 1, 0, 0, 0, 1, 0, R5);
    // contention: last=0 after first grant, so requester 1 leads
    step(1, 3, 1, 7, 1, 0, 0, 0, 0, 1, R7);
    step(1, 3, 1, 7, 1, 0, 0, 0, 1, 0, R3);
    step(1, 3, 1, 7, 1, 0, 0, 0, 0, 1, R7);
    step(1, 3, 1, 7, 1, 0, 0, 0, 1, 0, R3);
    step(0, 0, 1, 7, 1, 0, 0, 0, 0, 1, R7);
    // backpressure
    for (int i = 0; i < 3; i++) begin
      step(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_id", {31'd0, rsp_id}, 32'd1);
      chk("hold_data", rsp_data, R7);
    end
    step(1, 3, 0, 0, 1, 0, 0, 0, 1, 0, R3);
    // bypass, write to r0 ignored, r0 hard-wired zero
    step(0, 0, 1, 9, 1, 1, 9, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF);
    step(0, 0, 1, 0, 1, 1, 0, 32'h5555_5555, 0, 1, 32'h0);
    regs[0] = 32'hFFFF_FFFF;
    step(1, 0, 0, 0, 1, 1, 9, 32'h1111_1111, 1, 0, 32'h0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // async reset with a pending response
    step(1, 5, 0, 0, 0, 0, 0, 0, 1, 0, R5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pend_valid", {31'd0, rsp_valid}, 32'd1);
    #2 rst = 1;
    #1;
    chk("async_valid", {31'd0, rsp_valid}, 32'd0);
    chk("async_data", rsp_data, 32'd0);
    q.delete();
    rst = 0;
    @(posedge clk); #1;
    step(1, 3, 1, 7, 1, 0, 0, 0, 1, 0, R3);
    step(0, 0, 1, 7, 1, 0, 0, 0, 0, 1, R7);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("queue_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfiles_read_port.md
# regfiles_read_port

Two-requester read front end for the 32x32 register file built from the enabled asynchronous-reset flip-flop array. It reads the file's flattened storage bus, arbitrates between two read requesters (round-robin, valid/ready), forwards same-cycle write data, and returns one registered response per cycle. It sits between the register file and the datapath stages (operand fetch, debug/scan read) that consume register contents.

## Interface
- WIDTH, 32: data width of one register.
- DEPTH, 32: number of registers.
- AW, 5: address width; DEPTH = 2**AW.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- reg_flat  input  WIDTH*DEPTH  register array contents; register i occupies bits [i*WIDTH +: WIDTH].
- we  input  1  register-file write enable this cycle.
- waddr  input  AW  write address.
- wdata  input  WIDTH  write data.
- req0_valid  input  1  requester 0 read request.
- req0_addr  input  AW  requester 0 read address.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req1_valid  input  1  requester 1 read request.
- req1_addr  input  AW  requester 1 read address.
- req1_ready  output  1  requester 1 request accepted this cycle.
- rsp_valid  output  1  response holds valid data.
- rsp_id  output  1  requester the response belongs to (0 or 1).
- rsp_data  output  WIDTH  read data.
- rsp_ready  input  1  consumer takes the response this cycle.

## Operation
- Clock is clk; reset is asynchronous and active-high on rst.
- One response slot. can_accept = !rsp_valid | rsp_ready.
- Round-robin pointer `last` (1 bit): requester granted most recently. Priority goes to the other requester; a lone valid requester always wins.
- grant0 = req0_valid & (!req1_valid | last==1); grant1 = req1_valid & (!req0_valid | last==0).
- reqN_ready = grantN & can_accept. Combinational, no dependency on reqN_ready itself.
- Requester rule: once reqN_valid is high it stays high with stable addr until reqN_ready; the block does not rely on this for correctness but the bench checks it.
- On accept: rsp_valid<=1, rsp_id<=granted index, last<=granted index, rsp_data<=read value.
- Read value, in priority order: addr==0 -> 0 (register 0 is hard-wired zero); we & waddr==addr & waddr!=0 -> wdata (bypass); else reg_flat slice [addr*WIDTH +: WIDTH].
- No accept and rsp_ready high: rsp_valid<=0; rsp_id/rsp_data hold their last values.
- No accept and rsp_ready low: response holds unchanged.
- Write to register 0 is never forwarded.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, last=1 (requester 0 wins first contention). req0_ready/req1_ready=0 during reset.
- Latency: request accepted at edge N -> rsp_valid high after edge N, data present in cycle N+1.
- Throughput: one response per cycle while rsp_ready stays high; back-to-back contention alternates 0,1,0,1.
- Backpressure: rsp_valid & !rsp_ready -> both reqN_ready=0; rsp_id/rsp_data stable until taken.
- Same cycle: response taken and new request accepted -> new response replaces old with no bubble.
- Bypass is combinational from we/waddr/wdata in the accept cycle; no later write affects a captured response.
- rst asserted mid-operation: pending response dropped immediately (rsp_valid=0 asynchronously), pointer returns to last=1.

## Test plan
- Reset then req0_valid=1, addr=5, reg5=0x1234_5678, rsp_ready=1 -> req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=0x1234_5678.
- Both requesters valid continuously (addr 3 and 7), rsp_ready=1 -> grants 0,1,0,1...; rsp_id alternates, data matches reg3/reg7 each cycle.
- rsp_ready=0 for 3 cycles with response pending -> req readys low, rsp_data/rsp_id constant; rsp_ready=1 -> next request accepted same cycle, new response following cycle.
- we=1, waddr=9, wdata=0xDEAD_BEEF while req1 reads addr 9 (reg_flat still old 0x0) -> rsp_data=0xDEAD_BEEF; same with waddr=0, addr 0 -> rsp_data=0.
- Read addr 0 with reg_flat slice 0 forced to 0xFFFF_FFFF -> rsp_data=0.
- rst pulsed while rsp_valid=1 and rsp_ready=0 -> rsp_valid drops without a clock edge; after release, contention grants requester 0 first.
